n64_pi_bus_bridge: RTL and testbench
====================================

// Module: n64_pi_bus_bridge
// PURPOSE
//  Downstream of the N64 PI front-end: takes its 32-bit read/write request pulses and routes them to
//  the SDRAM or config-register target over a level request/ack handshake. Returns read data + ack,
//  and supplies the combinational address-valid flag the front-end samples with each read request.
//  2-entry command FIFO absorbs back-to-back PI requests; a timeout guards against a hung target.
// PARAMETERS
//  SDRAM_BASE      32'h1000_0000  SDRAM window base (aligned to 2**SDRAM_ADDR_BITS)
//  SDRAM_ADDR_BITS 26             SDRAM window size = 2**SDRAM_ADDR_BITS bytes (64 MiB)
//  CFG_BASE        32'h1FFF_0000  config window base, 32 bytes (addr[31:5] compare)
//  TIMEOUT_CYCLES  255            max cycles o_mem_rq may stay high without i_mem_ack (1..65535)
// PORTS
//  i_clk           in   1   clock
//  i_reset         in   1   synchronous, active-low reset
//  i_sdram_enable  in   1   1 = SDRAM window decodes; 0 = SDRAM window unmapped
//  i_read_rq       in   1   1-cycle read request pulse from PI front-end
//  i_write_rq      in   1   1-cycle write request pulse from PI front-end
//  i_address       in   32  request address (word aligned, bits[1:0] ignored)
//  i_data          in   32  write data, valid with i_write_rq
//  o_ack           out  1   1-cycle completion pulse (reads and writes)
//  o_data          out  32  read data, valid with o_ack of a read; held otherwise
//  o_address_valid out  1   combinational: i_address hits an enabled window
//  o_mem_rq        out  1   level request to target, held until i_mem_ack or timeout
//  o_mem_write     out  1   1 = write, 0 = read; stable while o_mem_rq
//  o_mem_target    out  1   0 = SDRAM, 1 = config; stable while o_mem_rq
//  o_mem_address   out  32  {addr[31:2],2'b00}, window offset (base removed); stable while o_mem_rq
//  o_mem_data      out  32  write data; stable while o_mem_rq
//  i_mem_ack       in   1   1-cycle ack from target; i_mem_data valid same cycle
//  i_mem_data      in   32  target read data
//  o_overflow      out  1   sticky: request dropped, FIFO full
//  o_timeout       out  1   sticky: a target request timed out
// BEHAVIOUR
//  Reset (i_reset=0): all outputs 0, FIFO emptied, FSM->IDLE, timeout counter 0, sticky flags cleared;
//   applies mid-transaction (o_mem_rq drops next edge, in-flight op lost, no o_ack). o_address_valid forced 0.
//  Decode: sdram_hit = i_sdram_enable && addr[31:SDRAM_ADDR_BITS]==SDRAM_BASE[31:SDRAM_ADDR_BITS];
//   cfg_hit = addr[31:5]==CFG_BASE[31:5]; o_address_valid = sdram_hit|cfg_hit, same cycle as i_address.
//  Push: on i_read_rq|i_write_rq, {write,target,mapped,offset,data} decoded and pushed into FIFO (depth 2).
//   Both rq high: treated as write, read dropped, o_overflow set. Push when full without same-cycle pop:
//   request dropped, o_overflow set. Push+pop same cycle when full is legal.
//  FSM IDLE: FIFO non-empty -> pop head. Mapped: o_mem_rq=1 next cycle, -> WAIT. Unmapped: o_ack=1
//   next cycle (read o_data=32'h0000_0000; write discarded), stay IDLE.
//  FSM WAIT: counter increments each cycle. i_mem_ack -> o_mem_rq=0, o_ack=1 next cycle, o_data<=i_mem_data
//   (reads only), -> IDLE. Counter reaches TIMEOUT_CYCLES without ack -> o_mem_rq=0, o_ack=1,
//   read o_data=32'hFFFF_FFFF, o_timeout=1, -> IDLE. Ack in same cycle as timeout: ack wins.
//  i_mem_ack outside WAIT ignored. Target must abandon a request when o_mem_rq drops.
//  Latency: rq at cycle N, FIFO empty+IDLE -> o_mem_rq high N+2; ack at M -> o_ack at M+1.
//   Unmapped: o_ack at N+2. Next command may issue the cycle after o_ack (back-to-back).
//  o_data changes only on read completion; write completions leave it unchanged.
// TESTING
//  Read 0x1000_0040, target ack 3 cycles later with 0xDEADBEEF -> o_mem_address=0x40,target=0, o_ack+o_data.
//  Write 0x1FFF_0004 data 0x12345678 -> o_mem_write=1,target=1,addr=0x4; o_ack; o_data unchanged.
//  Read 0x0800_0000, and 0x1000_0000 with i_sdram_enable=0 -> o_address_valid=0, o_ack@N+2, o_data=0.
//  Three rq pulses while target stalls -> first two served in order, third dropped, o_overflow=1.
//  Target never acks -> o_mem_rq high exactly TIMEOUT_CYCLES, o_data=0xFFFFFFFF, o_timeout=1.
//  Assert reset mid-WAIT -> o_mem_rq=0 next edge, no o_ack, FIFO empty, flags cleared.

Source files
------------

// File: rtl/n64_pi_bus_bridge_if.sv
// ---------------------------------------------------------------------------
// n64_pi_bus_bridge_if
// Bundles every bus-level signal of the PI bus bridge: the request side
// coming from the N64 PI front-end and the level request/ack side going to
// the SDRAM / config-register targets. Signal names keep the bridge's own
// i_/o_ direction prefixes so they read the same inside and outside it.
//   slave  : view used by the bridge (consumes i_*, drives o_*)
//   master : view used by the environment (drives i_*, consumes o_*)
// Front-end side : i_sdram_enable, i_read_rq, i_write_rq, i_address, i_data,
//                  o_ack, o_data, o_address_valid
// Target side    : o_mem_rq, o_mem_write, o_mem_target, o_mem_address,
//                  o_mem_data, i_mem_ack, i_mem_data
// Status         : o_overflow, o_timeout (sticky)
// ---------------------------------------------------------------------------
interface n64_pi_bus_bridge_if;
    logic        i_sdram_enable;
    logic        i_read_rq;
    logic        i_write_rq;
    logic [31:0] i_address;
    logic [31:0] i_data;
    logic        o_ack;
    logic [31:0] o_data;
    logic        o_address_valid;
    logic        o_mem_rq;
    logic        o_mem_write;
    logic        o_mem_target;
    logic [31:0] o_mem_address;
    logic [31:0] o_mem_data;
    logic        i_mem_ack;
    logic [31:0] i_mem_data;
    logic        o_overflow;
    logic        o_timeout;

    modport slave (
        input  i_sdram_enable, i_read_rq, i_write_rq, i_address, i_data,
        input  i_mem_ack, i_mem_data,
        output o_ack, o_data, o_address_valid,
        output o_mem_rq, o_mem_write, o_mem_target, o_mem_address, o_mem_data,
        output o_overflow, o_timeout
    );

    modport master (
        output i_sdram_enable, i_read_rq, i_write_rq, i_address, i_data,
        output i_mem_ack, i_mem_data,
        input  o_ack, o_data, o_address_valid,
        input  o_mem_rq, o_mem_write, o_mem_target, o_mem_address, o_mem_data,
        input  o_overflow, o_timeout
    );
endinterface

// File: rtl/n64_pi_bus_bridge.sv
// ---------------------------------------------------------------------------
// n64_pi_bus_bridge
// Routes 1-cycle read/write request pulses from the N64 PI front-end to the
// SDRAM or config-register target over a level request/ack handshake, and
// returns a 1-cycle completion pulse with read data. A 2-entry command FIFO
// absorbs back-to-back requests; a cycle counter abandons a hung target.
// Ports:
//   i_clk   : clock
//   i_reset : synchronous, active-low reset
//   bus     : n64_pi_bus_bridge_if.slave (front-end, target and status signals)
// o_address_valid is purely combinational from i_address / i_sdram_enable so
// the front-end can sample it in the same cycle as its read request.
// ---------------------------------------------------------------------------
module n64_pi_bus_bridge #(
    parameter logic [31:0] SDRAM_BASE      = 32'h1000_0000,
    parameter int          SDRAM_ADDR_BITS = 26,
    parameter logic [31:0] CFG_BASE        = 32'h1FFF_0000,
    parameter int          TIMEOUT_CYCLES  = 255
) (
    input logic               i_clk,
    input logic               i_reset,
    n64_pi_bus_bridge_if.slave bus
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    typedef struct packed {
        logic        write;
        logic        target;   // 0 = SDRAM, 1 = config
        logic        mapped;   // 0 = no window hit, completed locally
        logic [31:0] offset;   // window offset, word aligned
        logic [31:0] data;
    } cmd_t;

    localparam logic [31:0] SDRAM_OFF_MASK = ((32'h0000_0001 << SDRAM_ADDR_BITS) - 32'h0000_0001)
                                             & 32'hFFFF_FFFC;
    localparam logic [31:0] CFG_OFF_MASK   = 32'h0000_001C;
    // The request is in its last allowed cycle when the counter shows this.
    localparam logic [15:0] TIMEOUT_LAST   = 16'(TIMEOUT_CYCLES - 1);

    // ---------------- decode ----------------
    logic w_sdram_hit;
    logic w_cfg_hit;
    cmd_t w_new_cmd;

    assign w_sdram_hit = bus.i_sdram_enable &&
                         (bus.i_address[31:SDRAM_ADDR_BITS] == SDRAM_BASE[31:SDRAM_ADDR_BITS]);
    assign w_cfg_hit   = (bus.i_address[31:5] == CFG_BASE[31:5]);
    assign bus.o_address_valid = i_reset && (w_sdram_hit || w_cfg_hit);

    // Build the FIFO entry; the config window wins if a parameterisation ever overlaps the two.
    always_comb begin
        w_new_cmd.write  = bus.i_write_rq;
        w_new_cmd.target = w_cfg_hit;
        w_new_cmd.mapped = w_sdram_hit || w_cfg_hit;
        w_new_cmd.data   = bus.i_data;
        if (w_cfg_hit) begin
            w_new_cmd.offset = bus.i_address & CFG_OFF_MASK;
        end else if (w_sdram_hit) begin
            w_new_cmd.offset = bus.i_address & SDRAM_OFF_MASK;
        end else begin
            w_new_cmd.offset = 32'h0000_0000;
        end
    end

    // ---------------- command FIFO ----------------
    cmd_t        r_fifo [0:1];
    logic        r_wr_ptr;
    logic        r_rd_ptr;
    logic [1:0]  r_count;
    cmd_t        w_head;
    logic        w_rq_any;
    logic        w_rq_both;
    logic        w_full;
    logic        w_push;
    logic        w_drop;
    logic        w_pop;

    assign w_head    = r_fifo[r_rd_ptr];
    assign w_rq_any  = bus.i_read_rq || bus.i_write_rq;
    assign w_rq_both = bus.i_read_rq && bus.i_write_rq;
    assign w_full    = (r_count == 2'd2);
    // A pop in the same cycle frees a slot, so a full FIFO can still accept.
    assign w_push    = w_rq_any && (!w_full || w_pop);
    assign w_drop    = w_rq_any && w_full && !w_pop;

    // FIFO storage, pointers and occupancy.
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_fifo[0] <= '0;
            r_fifo[1] <= '0;
            r_wr_ptr  <= 1'b0;
            r_rd_ptr  <= 1'b0;
            r_count   <= 2'd0;
        end else begin
            if (w_push) begin
                r_fifo[r_wr_ptr] <= w_new_cmd;
                r_wr_ptr         <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
        end
    end

    // ---------------- FSM ----------------
    state_t      r_state;
    state_t      w_state_nxt;
    logic [15:0] r_cnt;
    logic [15:0] w_cnt_nxt;

    logic        r_ack,        w_ack_nxt;
    logic [31:0] r_data,       w_data_nxt;
    logic        r_mem_rq,     w_mem_rq_nxt;
    logic        r_mem_write,  w_mem_write_nxt;
    logic        r_mem_target, w_mem_target_nxt;
    logic [31:0] r_mem_addr,   w_mem_addr_nxt;
    logic [31:0] r_mem_wdata,  w_mem_wdata_nxt;
    logic        r_overflow,   w_overflow_nxt;
    logic        r_timeout,    w_timeout_nxt;

    // FSM state register.
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and next-output logic; every output register is computed here.
    always_comb begin
        w_state_nxt      = r_state;
        w_pop            = 1'b0;
        w_cnt_nxt        = r_cnt;
        w_ack_nxt        = 1'b0;
        w_data_nxt       = r_data;
        w_mem_rq_nxt     = r_mem_rq;
        w_mem_write_nxt  = r_mem_write;
        w_mem_target_nxt = r_mem_target;
        w_mem_addr_nxt   = r_mem_addr;
        w_mem_wdata_nxt  = r_mem_wdata;
        w_timeout_nxt    = r_timeout;
        w_overflow_nxt   = r_overflow || w_rq_both || w_drop;

        case (r_state)
            ST_IDLE: begin
                if (r_count != 2'd0) begin
                    w_pop = 1'b1;
                    if (w_head.mapped) begin
                        w_mem_rq_nxt     = 1'b1;
                        w_mem_write_nxt  = w_head.write;
                        w_mem_target_nxt = w_head.target;
                        w_mem_addr_nxt   = w_head.offset;
                        w_mem_wdata_nxt  = w_head.data;
                        w_cnt_nxt        = 16'd0;
                        w_state_nxt      = ST_WAIT;
                    end else begin
                        // Unmapped: complete locally; reads return zero, writes vanish.
                        w_ack_nxt = 1'b1;
                        if (!w_head.write) begin
                            w_data_nxt = 32'h0000_0000;
                        end else begin
                            w_data_nxt = r_data;
                        end
                    end
                end else begin
                    w_pop = 1'b0;
                end
            end
            ST_WAIT: begin
                // Ack is tested first so an ack in the timeout cycle still completes normally.
                if (bus.i_mem_ack) begin
                    w_mem_rq_nxt = 1'b0;
                    w_ack_nxt    = 1'b1;
                    w_state_nxt  = ST_IDLE;
                    if (!r_mem_write) begin
                        w_data_nxt = bus.i_mem_data;
                    end else begin
                        w_data_nxt = r_data;
                    end
                end else if (r_cnt == TIMEOUT_LAST) begin
                    w_mem_rq_nxt  = 1'b0;
                    w_ack_nxt     = 1'b1;
                    w_timeout_nxt = 1'b1;
                    w_state_nxt   = ST_IDLE;
                    if (!r_mem_write) begin
                        w_data_nxt = 32'hFFFF_FFFF;
                    end else begin
                        w_data_nxt = r_data;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + 16'd1;
                end
            end
            default: begin
                w_state_nxt  = ST_IDLE;
                w_mem_rq_nxt = 1'b0;
            end
        endcase
    end

    // Registered outputs, timeout counter and sticky status flags.
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_cnt        <= 16'd0;
            r_ack        <= 1'b0;
            r_data       <= 32'h0000_0000;
            r_mem_rq     <= 1'b0;
            r_mem_write  <= 1'b0;
            r_mem_target <= 1'b0;
            r_mem_addr   <= 32'h0000_0000;
            r_mem_wdata  <= 32'h0000_0000;
            r_overflow   <= 1'b0;
            r_timeout    <= 1'b0;
        end else begin
            r_cnt        <= w_cnt_nxt;
            r_ack        <= w_ack_nxt;
            r_data       <= w_data_nxt;
            r_mem_rq     <= w_mem_rq_nxt;
            r_mem_write  <= w_mem_write_nxt;
            r_mem_target <= w_mem_target_nxt;
            r_mem_addr   <= w_mem_addr_nxt;
            r_mem_wdata  <= w_mem_wdata_nxt;
            r_overflow   <= w_overflow_nxt;
            r_timeout    <= w_timeout_nxt;
        end
    end

    assign bus.o_ack         = r_ack;
    assign bus.o_data        = r_data;
    assign bus.o_mem_rq      = r_mem_rq;
    assign bus.o_mem_write   = r_mem_write;
    assign bus.o_mem_target  = r_mem_target;
    assign bus.o_mem_address = r_mem_addr;
    assign bus.o_mem_data    = r_mem_wdata;
    assign bus.o_overflow    = r_overflow;
    assign bus.o_timeout     = r_timeout;

endmodule

// File: tb/tb_n64_pi_bus_bridge.sv
// ---------------------------------------------------------------------------
// tb_n64_pi_bus_bridge
// Directed bench for n64_pi_bus_bridge: a linear sequence of stimulus steps
// with hand-computed expectations, checked one cycle at a time. Inputs change
// 1 time unit after the rising edge; outputs are read at the same point.
// ---------------------------------------------------------------------------
module tb_n64_pi_bus_bridge;

    logic clk;
    logic rst;
    int   n_vec;
    int   n_err;
    int   cycles;
    logic seen;

    n64_pi_bus_bridge_if bus ();

    n64_pi_bus_bridge dut (
        .i_clk   (clk),
        .i_reset (rst),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst                = 1'b0;
        bus.i_sdram_enable = 1'b1;
        bus.i_read_rq      = 1'b0;
        bus.i_write_rq     = 1'b0;
        bus.i_address      = 32'h1000_0040;
        bus.i_data         = 32'h0000_0000;
        bus.i_mem_ack      = 1'b0;
        bus.i_mem_data     = 32'h0000_0000;

        // ---- reset state ----
        tick(); tick(); tick();
        chk("rst_ack",    32'(bus.o_ack), 32'd0);
        chk("rst_mem_rq", 32'(bus.o_mem_rq), 32'd0);
        chk("rst_data",   bus.o_data, 32'h0000_0000);
        chk("rst_ovf",    32'(bus.o_overflow), 32'd0);
        chk("rst_tmo",    32'(bus.o_timeout), 32'd0);
        chk("rst_avalid", 32'(bus.o_address_valid), 32'd0);
        rst = 1'b1;
        tick();

        // ---- combinational decode ----
        chk("av_sdram",   32'(bus.o_address_valid), 32'd1);
        bus.i_address = 32'h1FFF_0004; #1;
        chk("av_cfg",     32'(bus.o_address_valid), 32'd1);
        bus.i_address = 32'h1FFF_0020; #1;
        chk("av_cfg_end", 32'(bus.o_address_valid), 32'd0);
        bus.i_address = 32'h13FF_FFFC; #1;
        chk("av_sd_top",  32'(bus.o_address_valid), 32'd1);
        bus.i_address = 32'h1400_0000; #1;
        chk("av_sd_past", 32'(bus.o_address_valid), 32'd0);

        // ---- SDRAM read, ack 3 cycles after o_mem_rq rises ----
        bus.i_address = 32'h1000_0040; bus.i_read_rq = 1'b1;
        tick();
        bus.i_read_rq = 1'b0;
        chk("rd_rq_n1",   32'(bus.o_mem_rq), 32'd0);
        tick();
        chk("rd_rq_n2",   32'(bus.o_mem_rq), 32'd1);
        chk("rd_write",   32'(bus.o_mem_write), 32'd0);
        chk("rd_target",  32'(bus.o_mem_target), 32'd0);
        chk("rd_addr",    bus.o_mem_address, 32'h0000_0040);
        tick(); tick();
        chk("rd_hold",    32'(bus.o_mem_rq), 32'd1);
        bus.i_mem_ack = 1'b1; bus.i_mem_data = 32'hDEAD_BEEF;
        tick();
        bus.i_mem_ack = 1'b0;
        chk("rd_ack",     32'(bus.o_ack), 32'd1);
        chk("rd_data",    bus.o_data, 32'hDEAD_BEEF);
        chk("rd_rq_drop", 32'(bus.o_mem_rq), 32'd0);
        tick();
        chk("rd_ack_end", 32'(bus.o_ack), 32'd0);

        // ---- config write ----
        bus.i_address = 32'h1FFF_0004; bus.i_data = 32'h1234_5678; bus.i_write_rq = 1'b1;
        tick();
        bus.i_write_rq = 1'b0;
        tick();
        chk("wr_rq",      32'(bus.o_mem_rq), 32'd1);
        chk("wr_write",   32'(bus.o_mem_write), 32'd1);
        chk("wr_target",  32'(bus.o_mem_target), 32'd1);
        chk("wr_addr",    bus.o_mem_address, 32'h0000_0004);
        chk("wr_wdata",   bus.o_mem_data, 32'h1234_5678);
        bus.i_mem_ack = 1'b1; bus.i_mem_data = 32'h5555_AAAA;
        tick();
        bus.i_mem_ack = 1'b0;
        chk("wr_ack",     32'(bus.o_ack), 32'd1);
        chk("wr_data_kept", bus.o_data, 32'hDEAD_BEEF);
        tick();

        // ---- unmapped: SDRAM window disabled, then a hole in the map ----
        bus.i_sdram_enable = 1'b0; bus.i_address = 32'h1000_0000; bus.i_read_rq = 1'b1; #1;
        chk("um1_avalid", 32'(bus.o_address_valid), 32'd0);
        tick();
        bus.i_read_rq = 1'b0;
        chk("um1_ack_n1", 32'(bus.o_ack), 32'd0);
        tick();
        chk("um1_ack_n2", 32'(bus.o_ack), 32'd1);
        chk("um1_data",   bus.o_data, 32'h0000_0000);
        chk("um1_no_rq",  32'(bus.o_mem_rq), 32'd0);
        tick();
        bus.i_sdram_enable = 1'b1; bus.i_address = 32'h0800_0000; bus.i_read_rq = 1'b1; #1;
        chk("um2_avalid", 32'(bus.o_address_valid), 32'd0);
        tick();
        bus.i_read_rq = 1'b0;
        tick();
        chk("um2_ack",    32'(bus.o_ack), 32'd1);
        chk("um2_data",   bus.o_data, 32'h0000_0000);
        tick();

        // ---- overflow: one request stalled at the target, three more arrive ----
        bus.i_address = 32'h1000_0100; bus.i_read_rq = 1'b1;
        tick();
        bus.i_read_rq = 1'b0;
        tick();
        chk("ov_first_rq", 32'(bus.o_mem_rq), 32'd1);
        bus.i_read_rq = 1'b1; bus.i_address = 32'h1000_0200;
        tick();
        bus.i_address = 32'h1000_0300;
        tick();
        chk("ov_not_yet", 32'(bus.o_overflow), 32'd0);
        bus.i_address = 32'h1000_0400;
        tick();
        bus.i_read_rq = 1'b0;
        chk("ov_set",     32'(bus.o_overflow), 32'd1);
        chk("ov_addr0",   bus.o_mem_address, 32'h0000_0100);
        bus.i_mem_ack = 1'b1; bus.i_mem_data = 32'h1111_1111;
        tick();
        bus.i_mem_ack = 1'b0;
        chk("ov_ack0",    bus.o_data, 32'h1111_1111);
        tick();
        chk("ov_b2b_rq",  32'(bus.o_mem_rq), 32'd1);
        chk("ov_addr1",   bus.o_mem_address, 32'h0000_0200);
        bus.i_mem_ack = 1'b1; bus.i_mem_data = 32'h2222_2222;
        tick();
        bus.i_mem_ack = 1'b0;
        chk("ov_ack1",    bus.o_data, 32'h2222_2222);
        tick();
        chk("ov_addr2",   bus.o_mem_address, 32'h0000_0300);
        bus.i_mem_ack = 1'b1; bus.i_mem_data = 32'h3333_3333;
        tick();
        bus.i_mem_ack = 1'b0;
        chk("ov_ack2",    bus.o_data, 32'h3333_3333);
        tick();
        chk("ov_dropped", 32'(bus.o_mem_rq), 32'd0);
        // stray ack while idle must be ignored
        bus.i_mem_ack = 1'b1; bus.i_mem_data = 32'hBADB_AD00;
        tick();
        bus.i_mem_ack = 1'b0;
        chk("idle_ack_ign", 32'(bus.o_ack), 32'd0);
        chk("idle_data",    bus.o_data, 32'h3333_3333);
        chk("ov_sticky",    32'(bus.o_overflow), 32'd1);

        // ---- timeout: target never acks ----
        bus.i_address = 32'h1000_0800; bus.i_read_rq = 1'b1;
        tick();
        bus.i_read_rq = 1'b0;
        tick();
        cycles = 0;
        while (bus.o_mem_rq && cycles < 400) begin
            cycles++;
            tick();
        end
        chk("tmo_len",    32'(cycles), 32'd255);
        chk("tmo_ack",    32'(bus.o_ack), 32'd1);
        chk("tmo_data",   bus.o_data, 32'hFFFF_FFFF);
        chk("tmo_flag",   32'(bus.o_timeout), 32'd1);
        tick();

        // ---- reset in the middle of WAIT with a queued request ----
        bus.i_address = 32'h1000_0010; bus.i_read_rq = 1'b1;
        tick();
        bus.i_read_rq = 1'b0;
        tick();
        chk("mr_rq",      32'(bus.o_mem_rq), 32'd1);
        bus.i_address = 32'h1000_0020; bus.i_read_rq = 1'b1;
        tick();
        bus.i_read_rq = 1'b0;
        rst = 1'b0;
        tick();
        chk("mr_rq_drop", 32'(bus.o_mem_rq), 32'd0);
        chk("mr_no_ack",  32'(bus.o_ack), 32'd0);
        chk("mr_ovf_clr", 32'(bus.o_overflow), 32'd0);
        chk("mr_tmo_clr", 32'(bus.o_timeout), 32'd0);
        rst = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            seen = seen | bus.o_mem_rq | bus.o_ack;
        end
        chk("mr_fifo_empty", 32'(seen), 32'd0);

        // ---- simultaneous read and write: write wins, overflow flagged ----
        bus.i_address = 32'h1FFF_0008; bus.i_data = 32'hCAFE_F00D;
        bus.i_read_rq = 1'b1; bus.i_write_rq = 1'b1;
        tick();
        bus.i_read_rq = 1'b0; bus.i_write_rq = 1'b0;
        chk("both_ovf",   32'(bus.o_overflow), 32'd1);
        tick();
        chk("both_rq",    32'(bus.o_mem_rq), 32'd1);
        chk("both_write", 32'(bus.o_mem_write), 32'd1);
        chk("both_addr",  bus.o_mem_address, 32'h0000_0008);
        chk("both_wdata", bus.o_mem_data, 32'hCAFE_F00D);
        bus.i_mem_ack = 1'b1; bus.i_mem_data = 32'h7777_7777;
        tick();
        bus.i_mem_ack = 1'b0;
        chk("both_ack",   32'(bus.o_ack), 32'd1);
        chk("both_data",  bus.o_data, 32'h0000_0000);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
